simd_alu_pipe: RTL

- Parametrised, registered SIMD ALU: LANES independent lanes of LANE_W bits each, all lanes running the same opcode.
- Keeps the existing 3-bit opcode map and neg/zero flag semantics, now reported per lane.
- Adds lane masking, a multi-cycle multiply, and a valid/ready handshake on input and output.
- Sits in the execute stage between operand read and writeback.

---
 rtl/simd_alu_pipe.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: LANES x LANE_W registered SIMD ALU with lane masking, multi-cycle multiply
// and valid/ready handshakes. Optional macro SIMD_ALU_SAT_EN adds signed saturation for add/sub.
module simd_alu_pipe #(
    parameter int LANES      = 4,
    parameter int LANE_W     = 8,
    parameter int MUL_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op,
    input  logic [LANES*LANE_W-1:0] operand_a,
    input  logic [LANES*LANE_W-1:0] operand_b,
    input  logic [LANES-1:0]        lane_mask,
`ifdef SIMD_ALU_SAT_EN
    input  logic                    sat,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] result,
    output logic [LANES-1:0]        neg_flags,
    output logic [LANES-1:0]        zero_flags,
    output logic                    busy
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int MSB   = LANE_W - 1;
    localparam int CNT_W = (MUL_STAGES > 2) ? $clog2(MUL_STAGES - 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST_C = CNT_W'((MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0);
    localparam logic [LANE_W-1:0] LW_C       = LANE_W[LANE_W-1:0];
    localparam logic [LANE_W-1:0] SMAX_C     = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN_C     = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [2:0]        OP_MUL_C   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                out_valid_q;
    logic [VEC_W-1:0]    result_q;
    logic [LANES-1:0]    neg_q;
    logic [LANES-1:0]    zero_q;
    logic [2:0]          op_q;
    logic [VEC_W-1:0]    a_q;
    logic [VEC_W-1:0]    b_q;
    logic [LANES-1:0]    mask_q;
    logic                sat_q;

    logic                in_ready_s;
    logic                accept_s;
    logic                sat_in_s;
    logic [2:0]          src_op_s;
    logic [VEC_W-1:0]    src_a_s;
    logic [VEC_W-1:0]    src_b_s;
    logic [LANES-1:0]    src_mask_s;
    logic                src_sat_s;
    logic [LANE_W-1:0]   lane_r_s;
    logic [VEC_W-1:0]    calc_res_s;
    logic [LANES-1:0]    calc_neg_s;
    logic [LANES-1:0]    calc_zero_s;

`ifdef SIMD_ALU_SAT_EN
    assign sat_in_s = sat;
`else
    assign sat_in_s = 1'b0;
`endif

    // One lane of the ALU; rotates use a doubled operand so any amount below LANE_W wraps cleanly.
    function automatic logic [LANE_W-1:0] lane_calc(input logic [2:0]        f_op,
                                                    input logic [LANE_W-1:0] a,
                                                    input logic [LANE_W-1:0] b,
                                                    input logic              s);
        logic [2*LANE_W-1:0] dbl;
        logic [LANE_W-1:0]   amt;
        logic [LANE_W-1:0]   sum;
        logic [LANE_W-1:0]   dif;
        logic [LANE_W-1:0]   r;
        amt = b % LW_C;
        sum = a + b;
        dif = a - b;
        dbl = {(2*LANE_W){1'b0}};
        case (f_op)
            3'b000: r = {LANE_W{1'b0}};
            3'b001: r = a ^ b;
            3'b010: r = (s && (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB])) ?
                        (a[MSB] ? SMIN_C : SMAX_C) : sum;
            3'b011: r = (s && (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB])) ?
                        (a[MSB] ? SMIN_C : SMAX_C) : dif;
            3'b100: r = a * b;
            3'b101: begin
                dbl = {a, a} >> amt;
                r   = dbl[LANE_W-1:0];
            end
            3'b110: begin
                dbl = {a, a} << amt;
                r   = dbl[2*LANE_W-1:LANE_W];
            end
            3'b111: r = a + {{(LANE_W-3){1'b0}}, 3'b100};
            default: r = {LANE_W{1'b0}};
        endcase
        return r;
    endfunction

    assign in_ready_s = !busy_q && (!out_valid_q || out_ready);
    assign accept_s   = in_valid && in_ready_s;

    // Lane datapath: live inputs on issue, the captured operands when a multiply completes.
    always_comb begin
        calc_res_s  = {VEC_W{1'b0}};
        calc_neg_s  = {LANES{1'b0}};
        calc_zero_s = {LANES{1'b0}};
        lane_r_s    = {LANE_W{1'b0}};
        if (state_q == MUL) begin
            src_op_s   = op_q;
            src_a_s    = a_q;
            src_b_s    = b_q;
            src_mask_s = mask_q;
            src_sat_s  = sat_q;
        end else begin
            src_op_s   = op;
            src_a_s    = operand_a;
            src_b_s    = operand_b;
            src_mask_s = lane_mask;
            src_sat_s  = sat_in_s;
        end
        for (int i = 0; i < LANES; i++) begin
            lane_r_s = lane_calc(src_op_s, src_a_s[i*LANE_W +: LANE_W],
                                 src_b_s[i*LANE_W +: LANE_W], src_sat_s);
            if (src_mask_s[i]) begin
                calc_res_s[i*LANE_W +: LANE_W] = lane_r_s;
                calc_zero_s[i] = (lane_r_s == {LANE_W{1'b0}});
                calc_neg_s[i]  = (src_a_s[i*LANE_W + MSB] != lane_r_s[MSB]) &&
                                 (lane_r_s != {LANE_W{1'b0}});
            end else begin
                calc_res_s[i*LANE_W +: LANE_W] = src_a_s[i*LANE_W +: LANE_W];
                calc_neg_s[i]  = 1'b0;
                calc_zero_s[i] = 1'b0;
            end
        end
    end

    // Control FSM with registered result, flags, valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {VEC_W{1'b0}};
            neg_q       <= {LANES{1'b0}};
            zero_q      <= {LANES{1'b0}};
            op_q        <= 3'b000;
            a_q         <= {VEC_W{1'b0}};
            b_q         <= {VEC_W{1'b0}};
            mask_q      <= {LANES{1'b0}};
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, OUT: begin
                    if (accept_s) begin
                        op_q   <= op;
                        a_q    <= operand_a;
                        b_q    <= operand_b;
                        mask_q <= lane_mask;
                        sat_q  <= sat_in_s;
                        if ((op == OP_MUL_C) && (MUL_STAGES > 1)) begin
                            state_q     <= MUL;
                            busy_q      <= 1'b1;
                            cnt_q       <= {CNT_W{1'b0}};
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                            result_q    <= calc_res_s;
                            neg_q       <= calc_neg_s;
                            zero_q      <= calc_zero_s;
                        end
                    end else if ((state_q == OUT) && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                MUL: begin
                    if (cnt_q == CNT_LAST_C) begin
                        state_q     <= OUT;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        result_q    <= calc_res_s;
                        neg_q       <= calc_neg_s;
                        zero_q      <= calc_zero_s;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign neg_flags  = neg_q;
    assign zero_flags = zero_q;
    assign busy       = busy_q;

endmodule
